// File: rtl/m_sequencer.sv
// m_sequencer: FSM that sequences the RV32M multiply/divide datapath selects.
// Ports: clk/reset; in_valid/in_ready/in_funct3 and the operand flags in_rs1_sign,
// in_rs2_sign, in_rs2_zero (issue side); sub_neg from the datapath; mux_A/B/R/D/Z
// datapath selects; out_valid/out_ready result handshake; out_sel_z (Z vs R holds
// the result); out_negate (consumer negates the result); busy (not IDLE).
module m_sequencer #(
  parameter int MUL_LATENCY  = 1,
  parameter int DIV_STEPS    = 32,
  parameter int MUX_A_LENGTH = 2,
  parameter int MUX_B_LENGTH = 2,
  parameter int MUX_R_LENGTH = 3,
  parameter int MUX_D_LENGTH = 2,
  parameter int MUX_Z_LENGTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_funct3,
  input  logic                    in_rs1_sign,
  input  logic                    in_rs2_sign,
  input  logic                    in_rs2_zero,
  input  logic                    sub_neg,
  output logic [MUX_A_LENGTH-1:0] mux_A,
  output logic [MUX_B_LENGTH-1:0] mux_B,
  output logic [MUX_R_LENGTH-1:0] mux_R,
  output logic [MUX_D_LENGTH-1:0] mux_D,
  output logic [MUX_Z_LENGTH-1:0] mux_Z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sel_z,
  output logic                    out_negate,
  output logic                    busy
);
  localparam logic [MUX_A_LENGTH-1:0] A_ZERO       = MUX_A_LENGTH'(0);
  localparam logic [MUX_A_LENGTH-1:0] A_R_SIGNED   = MUX_A_LENGTH'(1);
  localparam logic [MUX_A_LENGTH-1:0] A_R_UNSIGNED = MUX_A_LENGTH'(2);
  localparam logic [MUX_B_LENGTH-1:0] B_ZERO       = MUX_B_LENGTH'(0);
  localparam logic [MUX_B_LENGTH-1:0] B_D_SIGNED   = MUX_B_LENGTH'(1);
  localparam logic [MUX_B_LENGTH-1:0] B_D_UNSIGNED = MUX_B_LENGTH'(2);
  localparam logic [MUX_R_LENGTH-1:0] R_KEEP       = MUX_R_LENGTH'(0);
  localparam logic [MUX_R_LENGTH-1:0] R_A          = MUX_R_LENGTH'(1);
  localparam logic [MUX_R_LENGTH-1:0] R_A_NEG      = MUX_R_LENGTH'(2);
  localparam logic [MUX_R_LENGTH-1:0] R_MULT_LOWER = MUX_R_LENGTH'(3);
  localparam logic [MUX_R_LENGTH-1:0] R_SUB_KEEP   = MUX_R_LENGTH'(4);
  localparam logic [MUX_D_LENGTH-1:0] D_KEEP       = MUX_D_LENGTH'(0);
  localparam logic [MUX_D_LENGTH-1:0] D_B          = MUX_D_LENGTH'(1);
  localparam logic [MUX_D_LENGTH-1:0] D_B_NEG      = MUX_D_LENGTH'(2);
  localparam logic [MUX_D_LENGTH-1:0] D_SHR        = MUX_D_LENGTH'(3);
  localparam logic [MUX_Z_LENGTH-1:0] Z_KEEP       = MUX_Z_LENGTH'(0);
  localparam logic [MUX_Z_LENGTH-1:0] Z_ZERO       = MUX_Z_LENGTH'(1);
  localparam logic [MUX_Z_LENGTH-1:0] Z_MULT_UPPER = MUX_Z_LENGTH'(2);
  localparam logic [MUX_Z_LENGTH-1:0] Z_SHL_ADD    = MUX_Z_LENGTH'(3);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPS  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ITER = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  // One counter serves both WAIT and ITER, so size it for the longer of the two.
  localparam int CNT_MAX = (DIV_STEPS > MUL_LATENCY) ? DIV_STEPS : MUL_LATENCY;
  localparam int CW = $clog2(CNT_MAX + 1);
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_a_signed;
  logic          r_b_signed;
  logic          r_sel_z;
  logic          r_negate;
  logic [2:0]    w_next;
  logic          w_accept;
  logic          w_sdiv;
  logic          w_mul_phase;
  logic          w_unused;
  assign w_unused    = sub_neg;
  assign w_accept    = in_valid & (r_state == S_IDLE);
  assign w_sdiv      = in_funct3[2] & ~in_funct3[0];
  // The operand mode stays on mux_A/mux_B through WB so the upper word is signed correctly.
  assign w_mul_phase = (r_state == S_OPS) | (r_state == S_WAIT) | (r_state == S_WB);
  assign in_ready    = r_state == S_IDLE;
  assign busy        = r_state != S_IDLE;
  assign out_valid   = r_state == S_DONE;
  assign out_sel_z   = r_sel_z;
  assign out_negate  = r_negate;
  assign mux_A = w_mul_phase ? (r_a_signed ? A_R_SIGNED : A_R_UNSIGNED) : A_ZERO;
  assign mux_B = w_mul_phase ? (r_b_signed ? B_D_SIGNED : B_D_UNSIGNED) : B_ZERO;
  assign mux_R = w_accept ? ((w_sdiv & in_rs1_sign) ? R_A_NEG : R_A)
               : (r_state == S_WB) ? R_MULT_LOWER
               : (r_state == S_ITER) ? R_SUB_KEEP : R_KEEP;
  assign mux_D = w_accept ? ((w_sdiv & in_rs2_sign) ? D_B_NEG : D_B)
               : (r_state == S_ITER) ? D_SHR : D_KEEP;
  assign mux_Z = w_accept ? Z_ZERO
               : (r_state == S_WB) ? Z_MULT_UPPER
               : (r_state == S_ITER) ? Z_SHL_ADD : Z_KEEP;
  always_comb begin
    w_next = (r_state == S_IDLE) ? (w_accept ? (in_funct3[2] ? S_ITER : S_OPS) : S_IDLE)
           : (r_state == S_OPS)  ? S_WAIT
           : (r_state == S_WAIT) ? ((r_cnt == CW'(MUL_LATENCY - 1)) ? S_WB : S_WAIT)
           : (r_state == S_WB)   ? S_DONE
           : (r_state == S_ITER) ? ((r_cnt == CW'(DIV_STEPS - 1)) ? S_DONE : S_ITER)
           : (r_state == S_DONE) ? (out_ready ? S_IDLE : S_DONE) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a_signed <= 1'b0;
      r_b_signed <= 1'b0;
      r_sel_z    <= 1'b0;
      r_negate   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter clears on every state change so each WAIT/ITER run starts at 0.
      r_cnt   <= ((w_next == r_state) && ((r_state == S_WAIT) || (r_state == S_ITER))) ? r_cnt + CW'(1) : '0;
      if (w_accept) begin
        r_a_signed <= (in_funct3[1:0] != 2'd3);
        r_b_signed <= ~in_funct3[1];
        r_sel_z    <= in_funct3[2] ? ~in_funct3[1] : (in_funct3[1:0] != 2'd0);
        // Divide-by-zero leaves the quotient all-ones and the remainder as the dividend.
        r_negate   <= (in_funct3 == 3'd4) ? ((in_rs1_sign ^ in_rs2_sign) & ~in_rs2_zero)
                    : (in_funct3 == 3'd6) ? in_rs1_sign : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_m_sequencer.sv
// tb_m_sequencer: randomized self-checking bench for m_sequencer against a cycle-position model.
module tb_m_sequencer;
  localparam int ML = 1;
  localparam int DS = 32;
  localparam logic [1:0] A_ZERO = 2'd0, A_R_SIGNED = 2'd1, A_R_UNSIGNED = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd0, B_D_SIGNED = 2'd1, B_D_UNSIGNED = 2'd2;
  localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_A_NEG = 3'd2, R_MULT_LOWER = 3'd3, R_SUB_KEEP = 3'd4;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_MULT_UPPER = 2'd2, Z_SHL_ADD = 2'd3;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_rs1_sign, in_rs2_sign, in_rs2_zero, sub_neg;
  logic out_valid, out_ready, out_sel_z, out_negate, busy;
  logic [2:0] in_funct3, mux_R;
  logic [1:0] mux_A, mux_B, mux_D, mux_Z;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  m_sequencer #(.MUL_LATENCY(ML), .DIV_STEPS(DS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1_sign(in_rs1_sign), .in_rs2_sign(in_rs2_sign), .in_rs2_zero(in_rs2_zero), .sub_neg(sub_neg),
    .mux_A(mux_A), .mux_B(mux_B), .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel_z(out_sel_z), .out_negate(out_negate), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_sel(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic [2:0] r, input logic [1:0] d, input logic [1:0] z);
    check({tag, "_A"}, 32'(mux_A), 32'(a));
    check({tag, "_B"}, 32'(mux_B), 32'(b));
    check({tag, "_R"}, 32'(mux_R), 32'(r));
    check({tag, "_D"}, 32'(mux_D), 32'(d));
    check({tag, "_Z"}, 32'(mux_Z), 32'(z));
  endtask
  task automatic check_hs(input string tag, input logic rdy, input logic vld, input logic bsy);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(vld));
    check({tag, "_busy"}, 32'(busy), 32'(bsy));
  endtask
  task automatic junk();
    in_valid    = 1'($urandom_range(0, 1));
    in_funct3   = 3'($urandom_range(0, 7));
    in_rs1_sign = 1'($urandom_range(0, 1));
    in_rs2_sign = 1'($urandom_range(0, 1));
    in_rs2_zero = 1'($urandom_range(0, 1));
    sub_neg     = 1'($urandom_range(0, 1));
  endtask
  // Runs one operation; the model tracks only the cycle position since accept.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input int abort_at);
    bit is_div, sdiv, ez, en, last;
    int lat;
    logic [1:0] ea, eb;
    is_div = f >= 3'd4;
    sdiv   = (f == 3'd4) || (f == 3'd6);
    lat    = is_div ? DS + 1 : 3 + ML;
    ea     = (f <= 3'd2) ? A_R_SIGNED : A_R_UNSIGNED;
    eb     = (f <= 3'd1) ? B_D_SIGNED : B_D_UNSIGNED;
    ez     = f inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    en     = (f == 3'd4) ? (b != 0 && ($signed(a) < 0) != ($signed(b) < 0))
           : (f == 3'd6) ? ($signed(a) < 0) : 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_funct3 = f; in_rs1_sign = a[31]; in_rs2_sign = b[31];
    in_rs2_zero = (b == 0); sub_neg = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_hs("accept", 1'b1, 1'b0, 1'b0);
    check_sel("accept", A_ZERO, B_ZERO, (sdiv && a[31]) ? R_A_NEG : R_A,
              (sdiv && b[31]) ? D_B_NEG : D_B, Z_ZERO);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      junk();
      out_ready = (c < lat) ? 1'($urandom_range(0, 1)) : (hold == 0);
      @(negedge clk);
      if (c < lat) begin
        check_hs("run", 1'b0, 1'b0, 1'b1);
        last = c == lat - 1;
        if (is_div) check_sel("iter", A_ZERO, B_ZERO, R_SUB_KEEP, D_SHR, Z_SHL_ADD);
        else check_sel(last ? "wb" : "mulop", ea, eb, last ? R_MULT_LOWER : R_KEEP, D_KEEP,
                       last ? Z_MULT_UPPER : Z_KEEP);
      end
      if (c == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_hs("abort", 1'b1, 1'b0, 1'b0);
        check("abort_sel_z", 32'(out_sel_z), 32'd0);
        check("abort_negate", 32'(out_negate), 32'd0);
        return;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk); #1;
        junk();
        out_ready = (h == hold);
        @(negedge clk);
      end
      check_hs("done", 1'b0, 1'b1, 1'b1);
      check_sel("done", A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP);
      check("done_sel_z", 32'(out_sel_z), 32'(ez));
      check("done_negate", 32'(out_negate), 32'(en));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_hs("idle", 1'b1, 1'b0, 1'b0);
    check("idle_sel_z_kept", 32'(out_sel_z), 32'(ez));
    check("idle_negate_kept", 32'(out_negate), 32'(en));
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_funct3 = 3'd0; in_rs1_sign = 1'b0; in_rs2_sign = 1'b0;
    in_rs2_zero = 1'b0; sub_neg = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_hs("reset", 1'b1, 1'b0, 1'b0);
    check("reset_sel_z", 32'(out_sel_z), 32'd0);
    check("reset_negate", 32'(out_negate), 32'd0);
    check_sel("reset", A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP);
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd1, 32'h8000_0000, 32'd3, 1, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(3'd5, 32'd5, 32'd0, 0, 0);
    do_op(3'd4, 32'hFFFF_FFFB, 32'd0, 0, 0);
    do_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd7, 32'd9, 32'hFFFF_FFFE, 5, 0);
    do_op(3'd0, 32'd3, 32'd4, 5, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 10);
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    for (int i = 0; i < 24; i++)
      do_op(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
            $urandom_range(0, 3), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/m_sequencer.md
Name: m_sequencer

Overview:
- FSM controller for the M-extension multiply/divide register datapath.
- Accepts one RV32M operation at a time (funct3 encoding), drives the mux_A/mux_B/mux_R/mux_D/mux_Z selects cycle by cycle, and reports which datapath register holds the result and whether it must be negated.
- Sits between the custom-instruction issue interface and the datapath register block; owns no data registers.

Parameters:
- MUL_LATENCY, 1, number of WAIT cycles between the A/B operand capture and a valid registered product; range ≥1.
- DIV_STEPS, 32, restoring-division iterations; counter width is $clog2(DIV_STEPS+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request; rs1/rs2 are stable on the datapath inputs while high
- in_ready  out  1  high only in IDLE
- in_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1_sign  in  1  rs1[31]
- in_rs2_sign  in  1  rs2[31]
- in_rs2_zero  in  1  rs2 == 0
- sub_neg  in  1  subtractor result negative (datapath)
- mux_A  out  MUX_A_LENGTH  datapath select
- mux_B  out  MUX_B_LENGTH  datapath select
- mux_R  out  MUX_R_LENGTH  datapath select
- mux_D  out  MUX_D_LENGTH  datapath select
- mux_Z  out  MUX_Z_LENGTH  datapath select
- out_valid  out  1  result ready in datapath registers
- out_ready  in  1  consumer accepts result
- out_sel_z  out  1  1: result is Z; 0: result is R
- out_negate  out  1  consumer must two's-complement the selected register
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, dominant, also mid-operation): next state IDLE; out_valid=0, in_ready=1, busy=0, out_sel_z=0, out_negate=0, counters 0.
- Default selects in every state unless overridden: mux_R KEEP, mux_D KEEP, mux_Z KEEP, mux_A ZERO, mux_B ZERO.
- Op fields (funct3, signed flags, negate flags) are latched on accept (in_valid & in_ready). They are unchanged until the next accept.
- Accept cycle (Mealy, IDLE):
  - Signed divide (DIV, REM): mux_R = A_NEG if rs1_sign else A; mux_D = B_NEG if rs2_sign else B.
  - Multiplies and unsigned divides: mux_R = A, mux_D = B.
  - mux_Z = ZERO.
  - MUL* ops go to OPS; DIV/REM ops go to ITER with the counter cleared.
- OPS (1 cycle): mux_A = R_SIGNED for MUL, MULH, MULHSU, else R_UNSIGNED. mux_B = D_SIGNED for MUL, MULH, else D_UNSIGNED. Next state is WAIT.
- WAIT (MUL_LATENCY cycles): mux_A/mux_B hold the OPS values. Next state is WB.
- WB (1 cycle): mux_R = MULT_LOWER, mux_Z = MULT_UPPER. mux_A/mux_B hold the OPS values so the datapath's upper-word sign handling sees the correct mode. Next state is DONE.
- ITER (DIV_STEPS cycles): mux_R = SUB_KEEP, mux_Z = SHL_ADD, mux_D = SHR every cycle. The counter increments; after the DIV_STEPS-th cycle, next state is DONE. sub_neg is consumed by the datapath only; the FSM does not branch on it.
- DONE: out_valid=1 and is held until out_ready. On out_valid & out_ready, next state is IDLE. All selects are at their defaults. No new accept occurs in this cycle, because in_ready=0.
- out_sel_z: 1 for MULH, MULHSU, MULHU, DIV, DIVU; 0 for MUL, REM, REMU.
- out_negate:
  - DIV: rs1_sign ^ rs2_sign, forced 0 when rs2_zero (gives quotient 0xFFFFFFFF).
  - REM: rs1_sign, so the remainder takes the dividend's sign and divide-by-zero returns rs1.
  - All other ops: 0.
  - Overflow case DIV -2^31 / -1: negate=0, datapath yields 0x80000000, remainder 0. No special case is needed.
- Latency from accept to out_valid: multiplies 3+MUL_LATENCY cycles (4 at default); divides DIV_STEPS+1 cycles (33).
- in_valid while busy is ignored (no queue). funct3 is don't-care unless in_valid.

Test Plan:
- MUL, rs1=7, rs2=-3, out_ready=1 -> select sequence A/B, signed OPS, WAIT×1, WB; out_valid at cycle 4; out_sel_z=0, negate=0; R=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF and MULHSU -1×0xFFFFFFFF -> OPS drives R_UNSIGNED/D_UNSIGNED and R_SIGNED/D_UNSIGNED respectively, held through WB; Z=0xFFFFFFFE and 0xFFFFFFFF.
- DIV -7/2 -> accept uses A_NEG/B; exactly 32 ITER cycles; out_valid at cycle 33; out_sel_z=1, negate=1 (quotient -3). REM same operands -> sel_z=0, negate=1 (-1).
- DIVU 5/0 and DIV -5/0 -> out_sel_z=1, negate=0 (0xFFFFFFFF); REM -5/0 -> negate=1 (remainder -5).
- out_ready held low 5 cycles in DONE -> out_valid stays 1, in_ready=0, selects at defaults, in_valid ignored; IDLE the cycle after out_ready=1.
- reset asserted at ITER cycle 10 -> IDLE next cycle, out_valid=0, busy=0; a new MUL is accepted immediately and completes with the normal 4-cycle latency.
